// File: rtl/manycore_pkg.sv
// Shared types and constants for the manycore mesh: router port
// identifiers, the local transmitter state encoding and flit positions.
package manycore_pkg;

   typedef enum logic [2:0] {
      EAST  = 3'd0,
      WEST  = 3'd1,
      NORTH = 3'd2,
      SOUTH = 3'd3,
      LOCAL = 3'd4
   } e_port;

   typedef enum logic [2:0] {
      TX_IDLE    = 3'd0,
      TX_HEADER  = 3'd1,
      TX_SIZE    = 3'd2,
      TX_PAYLOAD = 3'd3,
      TX_DONE    = 3'd4
   } tx_state_e;

   // Position of the fixed flits at the front of every Hermes packet.
   localparam int FLIT_POS_HEADER = 0;
   localparam int FLIT_POS_SIZE   = 1;

endpackage

// File: rtl/flit_skid_fifo.sv
// Two-entry FIFO that buffers prefetched payload words ahead of the
// router. Slot 0 is always the head. Push and pop may happen in the same
// cycle, including when the FIFO is full.
module flit_skid_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] slot0_q, slot0_d;
   logic [WIDTH-1:0] slot1_q, slot1_d;
   logic [1:0]       count_q, count_d;
   logic [1:0]       wr_idx;

   // Next slot contents: a pop shifts slot 1 forward, a push lands in the
   // first slot that is free once the pop has been applied.
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      wr_idx  = count_q - 2'(pop);
      count_d = count_q + 2'(push) - 2'(pop);
      if (pop) begin
         slot0_d = slot1_q;
      end
      if (push) begin
         if (wr_idx == 2'd0) begin
            slot0_d = push_data;
         end else begin
            slot1_d = push_data;
         end
      end
   end

   // Occupancy is flushed by reset; data slots need no reset because the
   // count qualifies them.
   always_ff @(posedge clock) begin
      if (flush) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
      end
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
   end

   assign head  = slot0_q;
   assign count = count_q;

endmodule

// File: rtl/hermes_local_tx.sv
// Local-port packet injector: takes a descriptor, prefetches the payload
// from synchronous PE memory and sends header, size and payload flits to
// the router under credit flow control.
//
// Handshake: a flit moves on every cycle where tx=1 and credit_i=1. While
// tx=1 and credit_i=0 the flit (tx, data_o) is held unchanged; tx is never
// withdrawn before the flit has been accepted.
module hermes_local_tx
   import manycore_pkg::*;
#(
   parameter int FLIT_WIDTH       = 32,
   parameter int MEMORY_BUS_WIDTH = 32,
   parameter int MEM_ADDR_WIDTH   = 10,
   parameter int LEN_WIDTH        = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start_i,
   input  logic [FLIT_WIDTH-1:0]       dest_i,
   input  logic [LEN_WIDTH-1:0]        len_i,
   input  logic [MEM_ADDR_WIDTH-1:0]   base_addr_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        mem_en_o,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
   input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_i,
   output logic [FLIT_WIDTH-1:0]       data_o,
   output logic                        tx,
   input  logic                        credit_i,
   output logic                        clock_tx
);

   tx_state_e                 state_q, state_d;
   logic [FLIT_WIDTH-1:0]     dest_q;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [MEM_ADDR_WIDTH-1:0] base_q;
   logic [LEN_WIDTH-1:0]      rd_cnt_q;
   logic [LEN_WIDTH-1:0]      sent_cnt_q;
   logic [LEN_WIDTH-1:0]      sent_inc;
   logic                      inflight_q;
   logic                      pop;
   logic                      issue;
   logic                      active;
   logic [1:0]                fifo_count;
   logic [FLIT_WIDTH-1:0]     fifo_head;
   logic [2:0]                occupancy;
   logic [2:0]                limit;

   assign clock_tx = clock;
   assign sent_inc = sent_cnt_q + LEN_WIDTH'(1);

   // Packet sequencing: next state, flit presentation and FIFO pop.
   always_comb begin
      state_d = state_q;
      busy_o  = 1'b1;
      tx      = 1'b0;
      data_o  = '0;
      done_o  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         TX_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               state_d = TX_HEADER;
            end
         end
         TX_HEADER: begin
            tx     = 1'b1;
            data_o = dest_q;
            if (credit_i) begin
               state_d = TX_SIZE;
            end
         end
         TX_SIZE: begin
            tx     = 1'b1;
            data_o = FLIT_WIDTH'(len_q);
            if (credit_i) begin
               state_d = (len_q == '0) ? TX_DONE : TX_PAYLOAD;
            end
         end
         TX_PAYLOAD: begin
            if (fifo_count != 2'd0) begin
               tx     = 1'b1;
               data_o = fifo_head;
               if (credit_i) begin
                  pop = 1'b1;
                  if (sent_inc == len_q) begin
                     state_d = TX_DONE;
                  end
               end
            end
         end
         TX_DONE: begin
            done_o  = 1'b1;
            state_d = TX_IDLE;
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

   // Prefetch: keep buffered plus in-flight words at most two after this
   // cycle's pop, so the two-entry FIFO can never overflow.
   always_comb begin
      active     = (state_q == TX_HEADER) || (state_q == TX_SIZE) ||
                   (state_q == TX_PAYLOAD);
      occupancy  = 3'(fifo_count) + 3'(inflight_q);
      limit      = 3'd2 + 3'(pop);
      issue      = active && (rd_cnt_q < len_q) && (occupancy < limit);
      mem_en_o   = issue;
      mem_addr_o = issue ? (base_q + MEM_ADDR_WIDTH'(rd_cnt_q)) : '0;
   end

   // State, descriptor latch, read/sent counters and the in-flight flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= TX_IDLE;
         dest_q     <= '0;
         len_q      <= '0;
         base_q     <= '0;
         rd_cnt_q   <= '0;
         sent_cnt_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if ((state_q == TX_IDLE) && start_i) begin
            dest_q     <= dest_i;
            len_q      <= len_i;
            base_q     <= base_addr_i;
            rd_cnt_q   <= '0;
            sent_cnt_q <= '0;
         end else begin
            if (issue) begin
               rd_cnt_q <= rd_cnt_q + LEN_WIDTH'(1);
            end
            if (pop) begin
               sent_cnt_q <= sent_inc;
            end
         end
      end
   end

   // Read data is pushed the cycle after its strobe; reset clears the
   // in-flight flag so a word returning after reset is dropped.
   flit_skid_fifo #(
      .WIDTH(FLIT_WIDTH)
   ) u_fifo (
      .clock    (clock),
      .flush    (reset),
      .push     (inflight_q),
      .push_data(mem_data_i),
      .pop      (pop),
      .head     (fifo_head),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_hermes_local_tx.sv
// Bench for hermes_local_tx: a synchronous memory model, a packet-level
// reference (expected flit and read-address queues) and per-scenario tasks.
module tb_hermes_local_tx;

   localparam int FW = 32;
   localparam int AW = 10;
   localparam int LW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          start_i;
   logic [FW-1:0] dest_i;
   logic [LW-1:0] len_i;
   logic [AW-1:0] base_addr_i;
   logic          busy_o;
   logic          done_o;
   logic          mem_en_o;
   logic [AW-1:0] mem_addr_o;
   logic [FW-1:0] mem_data_i;
   logic [FW-1:0] data_o;
   logic          tx;
   logic          credit_i;
   logic          clock_tx;

   logic [FW-1:0] mem [0:1023];
   logic [FW-1:0] exp_q[$];
   logic [AW-1:0] addr_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;
   int            cyc      = 0;

   hermes_local_tx #(
      .FLIT_WIDTH(FW), .MEMORY_BUS_WIDTH(FW), .MEM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)
   ) dut (
      .clock(clock), .reset(reset), .start_i(start_i), .dest_i(dest_i),
      .len_i(len_i), .base_addr_i(base_addr_i), .busy_o(busy_o),
      .done_o(done_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
      .mem_data_i(mem_data_i), .data_o(data_o), .tx(tx),
      .credit_i(credit_i), .clock_tx(clock_tx)
   );

   // Clock
   always #5 clock = ~clock;

   // Cycle counter and synchronous one-cycle-latency memory
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mem_en_o) mem_data_i <= mem[mem_addr_o];
   end

   // Runs one packet. stall_flit is the absolute flit index (0 header,
   // 1 size, 2+k payload k) held off for stall_cycles; restart_cycle>0
   // pulses start_i that many cycles after acceptance; abort_after>0 asserts
   // reset once that many flits have been accepted.
   task automatic run_packet(input logic [FW-1:0] dest, input logic [LW-1:0] len,
                             input logic [AW-1:0] base, input int stall_flit,
                             input int stall_cycles, input int restart_cycle,
                             input int abort_after, output int acc_cyc,
                             output int done_cyc);
      int            n_acc = 0;
      int            stalls = 0;
      int            stall_rem = stall_cycles;
      int            rel;
      bit            got_done = 0;
      logic          prev_hold = 1'b0;
      logic [FW-1:0] prev_data = '0;
      logic [AW-1:0] a;
      logic [FW-1:0] e;
      exp_q.delete();
      addr_q.delete();
      exp_q.push_back(dest);
      exp_q.push_back(FW'(len));
      for (int k = 0; k < int'(len); k++) begin
         a = base + AW'(k);
         addr_q.push_back(a);
         exp_q.push_back(mem[a]);
      end
      done_cyc = -1;
      @(negedge clock);
      credit_i = 1'b1;
      #1;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b exp 0", busy_o); else n_pass++;
      start_i = 1'b1; dest_i = dest; len_i = len; base_addr_i = base;
      acc_cyc = cyc;
      @(posedge clock);
      #1;
      start_i = 1'b0; dest_i = $urandom; len_i = LW'($urandom); base_addr_i = AW'($urandom);
      for (int t = 0; t < 400 && !got_done; t++) begin
         @(negedge clock);
         rel = cyc - acc_cyc;
         start_i = (restart_cycle > 0 && rel == restart_cycle);
         if (abort_after > 0 && n_acc == abort_after) begin
            reset = 1'b1;
            @(posedge clock);
            #1 reset = 1'b0;
            @(negedge clock);
            #1;
            n_checks++;
            if (tx !== 1'b0) $display("FAIL abort_tx: got %b exp 0", tx); else n_pass++;
            n_checks++;
            if (busy_o !== 1'b0) $display("FAIL abort_busy: got %b exp 0", busy_o); else n_pass++;
            n_checks++;
            if (mem_en_o !== 1'b0) $display("FAIL abort_mem_en: got %b exp 0", mem_en_o); else n_pass++;
            n_checks++;
            if (data_o !== '0) $display("FAIL abort_data: got %h exp 0", data_o); else n_pass++;
            exp_q.delete();
            addr_q.delete();
            return;
         end
         if (tx && n_acc == stall_flit && stall_rem > 0) begin
            credit_i = 1'b0; stall_rem--; stalls++;
         end else begin
            credit_i = 1'b1;
         end
         #1;
         if (prev_hold) begin
            n_checks++;
            if (tx !== 1'b1 || data_o !== prev_data)
               $display("FAIL hold: got tx=%b data=%h exp tx=1 data=%h", tx, data_o, prev_data);
            else n_pass++;
         end
         if (tx !== 1'b1) begin
            n_checks++;
            if (data_o !== '0) $display("FAIL idle_data: got %h exp 0", data_o); else n_pass++;
         end
         if (tx === 1'b1 && credit_i) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL extra_flit: got %h exp none", data_o);
            else begin
               e = exp_q.pop_front();
               if (data_o !== e) $display("FAIL flit%0d: got %h exp %h", n_acc, data_o, e);
               else n_pass++;
            end
            n_acc++;
         end
         if (mem_en_o !== 1'b0) begin
            n_checks++;
            if (addr_q.size() == 0) $display("FAIL extra_read: got addr %h exp none", mem_addr_o);
            else begin
               a = addr_q.pop_front();
               if (mem_addr_o !== a) $display("FAIL rd_addr: got %h exp %h", mem_addr_o, a);
               else n_pass++;
            end
         end
         prev_hold = tx && !credit_i;
         prev_data = data_o;
         if (done_o === 1'b1) begin
            got_done = 1;
            done_cyc = cyc;
            n_checks++;
            if (rel !== 3 + int'(len) + stalls)
               $display("FAIL done_time: got %0d exp %0d", rel, 3 + int'(len) + stalls);
            else n_pass++;
            n_checks++;
            if (n_acc !== int'(len) + 2) $display("FAIL flit_count: got %0d exp %0d", n_acc, int'(len) + 2);
            else n_pass++;
            n_checks++;
            if (exp_q.size() != 0 || addr_q.size() != 0)
               $display("FAIL leftover: got %0d flits %0d reads exp 0 0", exp_q.size(), addr_q.size());
            else n_pass++;
            n_checks++;
            if (busy_o !== 1'b1) $display("FAIL done_busy: got %b exp 1", busy_o); else n_pass++;
         end
      end
      start_i = 1'b0;
      credit_i = 1'b1;
      if (!got_done) begin
         n_checks++;
         $display("FAIL timeout: got no done_o exp done_o within 400 cycles");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start_i = 1'b0; credit_i = 1'b1;
      dest_i = '0; len_i = '0; base_addr_i = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      #1;
      n_checks++;
      if (tx !== 1'b0) $display("FAIL rst_tx: got %b exp 0", tx); else n_pass++;
      n_checks++;
      if (data_o !== '0) $display("FAIL rst_data: got %h exp 0", data_o); else n_pass++;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy_o); else n_pass++;
      n_checks++;
      if (done_o !== 1'b0) $display("FAIL rst_done: got %b exp 0", done_o); else n_pass++;
      n_checks++;
      if (mem_en_o !== 1'b0) $display("FAIL rst_mem_en: got %b exp 0", mem_en_o); else n_pass++;
      n_checks++;
      if (mem_addr_o !== '0) $display("FAIL rst_mem_addr: got %h exp 0", mem_addr_o); else n_pass++;
      n_checks++;
      if (clock_tx !== clock) $display("FAIL clock_tx_lo: got %b exp %b", clock_tx, clock); else n_pass++;
      reset = 1'b0;
      @(posedge clock);
      #1;
      n_checks++;
      if (clock_tx !== clock) $display("FAIL clock_tx_hi: got %b exp %b", clock_tx, clock); else n_pass++;
   endtask

   task automatic test_basic();
      int a, d;
      run_packet(32'h0101, 16'd3, 10'h010, -1, 0, 0, 0, a, d);
   endtask

   task automatic test_zero_len();
      int a, d;
      run_packet(32'h0001, 16'd0, AW'($urandom), -1, 0, 0, 0, a, d);
   endtask

   task automatic test_stall();
      int a, d;
      run_packet($urandom, 16'd4, AW'($urandom), 3, 3, 0, 0, a, d);
   endtask

   task automatic test_wrap();
      int a, d;
      run_packet($urandom, 16'd4, 10'h3FE, -1, 0, 0, 0, a, d);
   endtask

   task automatic test_restart_ignored();
      int a, d;
      run_packet($urandom, 16'd5, AW'($urandom), -1, 0, 3, 0, a, d);
      repeat (4) begin
         @(negedge clock);
         #1;
         n_checks++;
         if (tx !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL after_restart: got tx=%b busy=%b exp 0 0", tx, busy_o);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int a, d;
      run_packet($urandom, 16'd8, AW'($urandom), -1, 0, 0, 5, a, d);
      run_packet($urandom, 16'd2, AW'($urandom), -1, 0, 0, 0, a, d);
   endtask

   task automatic test_back_to_back();
      int a1, d1, a2, d2;
      run_packet($urandom, LW'($urandom_range(0, 6)), AW'($urandom), -1, 0, 0, 0, a1, d1);
      run_packet($urandom, LW'($urandom_range(0, 6)), AW'($urandom), -1, 0, 0, 0, a2, d2);
      n_checks++;
      if (a2 !== d1 + 1) $display("FAIL back_to_back: got accept %0d exp %0d", a2, d1 + 1);
      else n_pass++;
   endtask

   task automatic test_random();
      int a, d, len;
      for (int i = 0; i < 8; i++) begin
         len = $urandom_range(0, 9);
         run_packet($urandom, LW'(len), AW'($urandom), $urandom_range(0, len + 1),
                    $urandom_range(0, 4), 0, 0, a, d);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      test_reset();
      test_basic();
      test_zero_len();
      test_stall();
      test_wrap();
      test_restart_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
